config_chain_loader: RTL

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/config_chain_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/config_chain_loader.sv
// Configuration scan-chain loader: takes a word-wide bitstream over a valid/ready
// handshake and serialises it LSB-first into a chain of CHAIN_LEN flip-flops.
module config_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [WORD_W-1:0] WORD_IN,
    input  logic              WORD_VALID,
    output logic              WORD_READY,
    output logic              CCFF_HEAD,
    output logic              CCFF_EN,
    output logic              IO_ISOL_N,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int NW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        SHIFT,
        FIN
    } state_t;

    state_t            state, state_next;
    logic [BW-1:0]     bits_done, bits_next;
    logic [TW-1:0]     tcnt, tcnt_next;
    logic [NW-1:0]     bit_cnt, bit_cnt_next;
    logic [NW-1:0]     nb, nb_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic [BW-1:0]     remaining;
    logic              err_q, err_next;
    logic              isol_q, isol_next;
    logic              en_q, en_next;
    logic              head_q, head_next;
    logic              handshake;

    assign WORD_READY = (state == WAIT_WORD) && !ABORT;
    assign handshake  = WORD_VALID && WORD_READY;
    assign remaining  = BW'(CHAIN_LEN) - bits_done;

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= IDLE;
            bits_done <= '0;
            tcnt      <= '0;
            bit_cnt   <= '0;
            nb        <= '0;
            shift_reg <= '0;
            err_q     <= 1'b0;
            isol_q    <= 1'b0;
            en_q      <= 1'b0;
            head_q    <= 1'b0;
        end else begin
            state     <= state_next;
            bits_done <= bits_next;
            tcnt      <= tcnt_next;
            bit_cnt   <= bit_cnt_next;
            nb        <= nb_next;
            shift_reg <= shift_next;
            err_q     <= err_next;
            isol_q    <= isol_next;
            en_q      <= en_next;
            head_q    <= head_next;
        end
    end

    // ABORT is tested first in the busy states so it beats handshake, timeout and completion.
    always_comb begin
        state_next   = state;
        bits_next    = bits_done;
        tcnt_next    = tcnt;
        bit_cnt_next = bit_cnt;
        nb_next      = nb;
        shift_next   = shift_reg;
        err_next     = err_q;
        isol_next    = isol_q;

        case (state)
            IDLE: begin
                if (START) begin
                    state_next   = WAIT_WORD;
                    bits_next    = '0;
                    tcnt_next    = '0;
                    bit_cnt_next = '0;
                    err_next     = 1'b0;
                    isol_next    = 1'b0;
                end
            end
            WAIT_WORD: begin
                if (ABORT) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                    isol_next  = 1'b0;
                end else if (handshake) begin
                    state_next   = SHIFT;
                    shift_next   = WORD_IN;
                    tcnt_next    = '0;
                    bit_cnt_next = '0;
                    if (32'(remaining) < WORD_W) begin
                        nb_next = NW'(remaining);
                    end else begin
                        nb_next = NW'(WORD_W);
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    tcnt_next  = tcnt + TW'(1);
                    err_next   = 1'b1;
                end else begin
                    tcnt_next = tcnt + TW'(1);
                end
            end
            SHIFT: begin
                if (ABORT) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                    isol_next  = 1'b0;
                end else begin
                    shift_next = shift_reg >> 1;
                    bits_next  = bits_done + BW'(1);
                    if ((bit_cnt + NW'(1)) == nb) begin
                        bit_cnt_next = '0;
                        if ((bits_done + BW'(1)) == BW'(CHAIN_LEN)) begin
                            state_next = FIN;
                            isol_next  = 1'b1;
                        end else begin
                            state_next = WAIT_WORD;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + NW'(1);
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        en_next   = (state_next == SHIFT);
        head_next = en_next ? shift_next[0] : 1'b0;
    end

    assign CCFF_EN   = en_q;
    assign CCFF_HEAD = head_q;
    assign IO_ISOL_N = isol_q;
    assign ERR       = err_q;
    assign DONE      = (state == FIN);
    assign BUSY      = (state == WAIT_WORD) || (state == SHIFT);

endmodule
